// File: rtl/ram_sdp_arbiter_512x32.sv
// Controller and arbiter for a simple dual-port RAM (one write port, one
// synchronous read port with 1-cycle latency) shared by two requesters.
//
// State table:
//   state   | meaning
//   ST_INIT | fill sweep: write INIT_VAL to every address, no grants issued
//   ST_RUN  | normal operation: independent round-robin on write and read ports
//
// Ports:
//   clk, reset (async, active-low), clear (restart fill sweep)
//   init_done                      : high while in ST_RUN
//   wr_req/addr/data/gnt_{0,1}     : client write ports, gnt is combinational
//   rd_req/addr/gnt_{0,1}          : client read request ports, gnt combinational
//   rd_valid/data_{0,1}            : read response, one cycle after grant
//   ram_we/waddr/wdata             : RAM write port
//   ram_re/raddr/rdata             : RAM read port (rdata valid cycle after re)
module ram_sdp_arbiter_512x32 #(
  parameter int                ADDR_W   = 9,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  output logic              init_done,
  input  logic              wr_req_0,
  input  logic [ADDR_W-1:0] wr_addr_0,
  input  logic [DATA_W-1:0] wr_data_0,
  output logic              wr_gnt_0,
  input  logic              wr_req_1,
  input  logic [ADDR_W-1:0] wr_addr_1,
  input  logic [DATA_W-1:0] wr_data_1,
  output logic              wr_gnt_1,
  input  logic              rd_req_0,
  input  logic [ADDR_W-1:0] rd_addr_0,
  output logic              rd_gnt_0,
  output logic              rd_valid_0,
  output logic [DATA_W-1:0] rd_data_0,
  input  logic              rd_req_1,
  input  logic [ADDR_W-1:0] rd_addr_1,
  output logic              rd_gnt_1,
  output logic              rd_valid_1,
  output logic [DATA_W-1:0] rd_data_1,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  // One extra counter bit keeps the terminal compare unambiguous.
  localparam logic [ADDR_W:0] FILL_LAST = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [ADDR_W:0]   cnt, cnt_nxt;
  logic              last_wr, last_rd;
  logic              col_q;
  logic [DATA_W-1:0] col_data_q;
  logic [DATA_W-1:0] rd_hold_0, rd_hold_1;
  logic [DATA_W-1:0] rd_resp;

  assign init_done = (state == ST_RUN);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_gnt_0  = 1'b0;
    wr_gnt_1  = 1'b0;
    rd_gnt_0  = 1'b0;
    rd_gnt_1  = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    ram_re    = 1'b0;
    ram_raddr = '0;
    case (state)
      ST_INIT: begin
        // Gated by reset so the RAM sees no write while reset is held.
        ram_we    = reset;
        ram_waddr = cnt[ADDR_W-1:0];
        ram_wdata = INIT_VAL;
        if (clear) begin
          cnt_nxt = '0;
        end else if (cnt == FILL_LAST) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_RUN: begin
        // On a tie the requester that was not granted last wins.
        wr_gnt_0 = wr_req_0 & (~wr_req_1 | last_wr);
        wr_gnt_1 = wr_req_1 & (~wr_req_0 | ~last_wr);
        rd_gnt_0 = rd_req_0 & (~rd_req_1 | last_rd);
        rd_gnt_1 = rd_req_1 & (~rd_req_0 | ~last_rd);
        if (wr_gnt_1) begin
          ram_we    = 1'b1;
          ram_waddr = wr_addr_1;
          ram_wdata = wr_data_1;
        end else if (wr_gnt_0) begin
          ram_we    = 1'b1;
          ram_waddr = wr_addr_0;
          ram_wdata = wr_data_0;
        end
        if (rd_gnt_1) begin
          ram_re    = 1'b1;
          ram_raddr = rd_addr_1;
        end else if (rd_gnt_0) begin
          ram_re    = 1'b1;
          ram_raddr = rd_addr_0;
        end
        if (clear) begin
          state_nxt = ST_INIT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_INIT;
      cnt        <= '0;
      last_wr    <= 1'b1;
      last_rd    <= 1'b1;
      rd_valid_0 <= 1'b0;
      rd_valid_1 <= 1'b0;
      col_q      <= 1'b0;
      col_data_q <= '0;
      rd_hold_0  <= '0;
      rd_hold_1  <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      if (wr_gnt_0 | wr_gnt_1) last_wr <= wr_gnt_1;
      if (rd_gnt_0 | rd_gnt_1) last_rd <= rd_gnt_1;
      rd_valid_0 <= rd_gnt_0;
      rd_valid_1 <= rd_gnt_1;
      // The RAM is read-first; clients see write-first on a same-address hit.
      col_q      <= ram_we & ram_re & (ram_waddr == ram_raddr);
      col_data_q <= ram_wdata;
      if (rd_valid_0) rd_hold_0 <= rd_resp;
      if (rd_valid_1) rd_hold_1 <= rd_resp;
    end
  end

  assign rd_resp   = col_q ? col_data_q : ram_rdata;
  assign rd_data_0 = rd_valid_0 ? rd_resp : rd_hold_0;
  assign rd_data_1 = rd_valid_1 ? rd_resp : rd_hold_1;

endmodule

// File: tb/tb_ram_sdp_arbiter_512x32.sv
module tb_ram_sdp_arbiter_512x32;
  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        reset, clear;
  logic        init_done;
  logic        wr_req_0, wr_req_1, rd_req_0, rd_req_1;
  logic [8:0]  wr_addr_0, wr_addr_1, rd_addr_0, rd_addr_1;
  logic [31:0] wr_data_0, wr_data_1;
  logic        wr_gnt_0, wr_gnt_1, rd_gnt_0, rd_gnt_1;
  logic        rd_valid_0, rd_valid_1;
  logic [31:0] rd_data_0, rd_data_1;
  logic        ram_we, ram_re;
  logic [8:0]  ram_waddr, ram_raddr;
  logic [31:0] ram_wdata, ram_rdata;

  int tests = 0;
  int fails = 0;

  ram_sdp_arbiter_512x32 dut (
    .clk(clk), .reset(reset), .clear(clear), .init_done(init_done),
    .wr_req_0(wr_req_0), .wr_addr_0(wr_addr_0), .wr_data_0(wr_data_0), .wr_gnt_0(wr_gnt_0),
    .wr_req_1(wr_req_1), .wr_addr_1(wr_addr_1), .wr_data_1(wr_data_1), .wr_gnt_1(wr_gnt_1),
    .rd_req_0(rd_req_0), .rd_addr_0(rd_addr_0), .rd_gnt_0(rd_gnt_0),
    .rd_valid_0(rd_valid_0), .rd_data_0(rd_data_0),
    .rd_req_1(rd_req_1), .rd_addr_1(rd_addr_1), .rd_gnt_1(rd_gnt_1),
    .rd_valid_1(rd_valid_1), .rd_data_1(rd_data_1),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Read-first synchronous RAM macro model.
  logic [31:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_re) ram_rdata <= ram_mem[ram_raddr];
    if (ram_we) ram_mem[ram_waddr] <= ram_wdata;
  end

  // Reference model state: what the clients should see as memory contents.
  logic [31:0] ref_mem [DEPTH];
  logic        m_last_wr, m_last_rd;
  logic [31:0] exp_rd0, exp_rd1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, expected run to finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Round-robin rule: a lone requester wins; on a tie, the one not granted last.
  function automatic logic [3:0] model_gnt(input logic w0, w1, r0, r1);
    logic wg0, wg1, rg0, rg1;
    if (w0 && w1) begin wg1 = (m_last_wr == 1'b0); wg0 = !wg1; end
    else begin wg0 = w0; wg1 = w1; end
    if (r0 && r1) begin rg1 = (m_last_rd == 1'b0); rg0 = !rg1; end
    else begin rg0 = r0; rg1 = r1; end
    return {wg0, wg1, rg0, rg1};
  endfunction

  // One RUN cycle: drive, check combinational grant/RAM side, clock,
  // then check the read responses. eg = {wr_gnt_0, wr_gnt_1, rd_gnt_0, rd_gnt_1}.
  task automatic step(input logic clr, w0, w1, r0, r1,
                      input logic [8:0] wa0, wa1, ra0, ra1,
                      input logic [31:0] wd0, wd1,
                      input logic [3:0] eg, input string tag);
    logic        ewe, ere;
    logic [8:0]  ewa, era;
    logic [31:0] ewd, er;
    clear = clr;
    wr_req_0 = w0; wr_req_1 = w1; rd_req_0 = r0; rd_req_1 = r1;
    wr_addr_0 = wa0; wr_addr_1 = wa1; rd_addr_0 = ra0; rd_addr_1 = ra1;
    wr_data_0 = wd0; wr_data_1 = wd1;
    #1;
    check({tag, "_gnt"}, {60'h0, wr_gnt_0, wr_gnt_1, rd_gnt_0, rd_gnt_1}, {60'h0, eg});
    ewe = eg[3] | eg[2];
    ere = eg[1] | eg[0];
    ewa = eg[2] ? wa1 : wa0;
    ewd = eg[2] ? wd1 : wd0;
    era = eg[0] ? ra1 : ra0;
    check({tag, "_wport"}, {ram_we, ram_we ? ram_waddr : 9'h0, ram_we ? ram_wdata : 32'h0},
          {ewe, ewe ? ewa : 9'h0, ewe ? ewd : 32'h0});
    check({tag, "_rport"}, {ram_re, ram_re ? ram_raddr : 9'h0}, {ere, ere ? era : 9'h0});
    er = 32'h0;
    if (ere) er = (ewe && ewa == era) ? ewd : ref_mem[era];
    if (ewe) begin ref_mem[ewa] = ewd; m_last_wr = eg[2]; end
    if (ere) m_last_rd = eg[0];
    if (eg[1]) exp_rd0 = er;
    if (eg[0]) exp_rd1 = er;
    @(posedge clk); #1;
    clear = 1'b0;
    check({tag, "_valid"}, {rd_valid_0, rd_valid_1}, eg[1:0]);
    check({tag, "_rdata0"}, rd_data_0, exp_rd0);
    check({tag, "_rdata1"}, rd_data_1, exp_rd1);
    if (clr) check({tag, "_init_done_fall"}, init_done, 1'b0);
  endtask

  // Fill sweep starting at address 0; requests held high must not be granted.
  task automatic sweep(input int n);
    clear = 1'b0;
    wr_req_0 = 1'b1; wr_req_1 = 1'b1; rd_req_0 = 1'b1; rd_req_1 = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      check("sweep", {init_done, ram_we, ram_waddr, ram_wdata, ram_re,
                      wr_gnt_0, wr_gnt_1, rd_gnt_0, rd_gnt_1},
            {1'b0, 1'b1, 9'(i), 32'h0, 1'b0, 4'b0000});
      @(posedge clk); #1;
    end
    if (n == DEPTH) begin
      for (int a = 0; a < DEPTH; a++) ref_mem[a] = 32'h0;
      wr_req_0 = 1'b0; wr_req_1 = 1'b0; rd_req_0 = 1'b0; rd_req_1 = 1'b0;
      #1;
      check("sweep_done", {init_done, ram_we, ram_re}, 3'b100);
    end
  endtask

  task automatic reset_model();
    m_last_wr = 1'b1; m_last_rd = 1'b1;
    exp_rd0 = 32'h0; exp_rd1 = 32'h0;
  endtask

  task automatic random_run(input int cycles);
    logic        w0, w1, r0, r1;
    logic [8:0]  wa0, wa1, ra0, ra1;
    logic [31:0] wd0, wd1;
    logic [3:0]  eg;
    w0 = 0; w1 = 0; r0 = 0; r1 = 0;
    wa0 = 0; wa1 = 0; ra0 = 0; ra1 = 0; wd0 = 0; wd1 = 0;
    for (int c = 0; c < cycles; c++) begin
      // Requests stay asserted with stable payload until granted.
      if (!w0) begin w0 = 1'($urandom_range(0, 1)); wa0 = 9'($urandom_range(0, 7)); wd0 = $urandom; end
      if (!w1) begin w1 = 1'($urandom_range(0, 1)); wa1 = 9'($urandom_range(0, 7)); wd1 = $urandom; end
      if (!r0) begin r0 = 1'($urandom_range(0, 1)); ra0 = 9'($urandom_range(0, 7)); end
      if (!r1) begin r1 = 1'($urandom_range(0, 1)); ra1 = 9'($urandom_range(0, 7)); end
      eg = model_gnt(w0, w1, r0, r1);
      step(1'b0, w0, w1, r0, r1, wa0, wa1, ra0, ra1, wd0, wd1, eg, "rand");
      if (eg[3]) w0 = 1'b0;
      if (eg[2]) w1 = 1'b0;
      if (eg[1]) r0 = 1'b0;
      if (eg[0]) r1 = 1'b0;
    end
  endtask

  typedef struct {
    logic       w0, w1, r0, r1;
    logic [3:0] eg;
  } vec_t;

  vec_t tbl [10];

  initial begin
    // Arbitration sequence starting from the reset tie-break (requester 0 first).
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'b1010};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'b0101};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'b1010};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'b0101};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b0110};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'b1001};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'b0110};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'b1001};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};

    for (int a = 0; a < DEPTH; a++) ram_mem[a] = $urandom;
    ram_rdata = 32'h0;
    reset_model();

    // Reset held with every request asserted.
    reset = 1'b0; clear = 1'b0;
    wr_req_0 = 1'b1; wr_req_1 = 1'b1; rd_req_0 = 1'b1; rd_req_1 = 1'b1;
    wr_addr_0 = 9'h0; wr_addr_1 = 9'h0; rd_addr_0 = 9'h0; rd_addr_1 = 9'h0;
    wr_data_0 = 32'h0; wr_data_1 = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {init_done, ram_we, ram_re, wr_gnt_0, wr_gnt_1, rd_gnt_0, rd_gnt_1,
                          rd_valid_0, rd_valid_1}, 9'h0);
    check("reset_rdata", {rd_data_0, rd_data_1}, 64'h0);
    reset = 1'b1;
    sweep(DEPTH);

    for (int i = 0; i < 10; i++)
      step(1'b0, tbl[i].w0, tbl[i].w1, tbl[i].r0, tbl[i].r1,
           9'(9'h100 + i), 9'(9'h180 + i), 9'(9'h100 + i), 9'(9'h180 + i),
           $urandom, $urandom, tbl[i].eg, "table");

    step(1'b0, 1, 0, 0, 0, 9'h005, 9'h0, 9'h0, 9'h0, 32'hDEADBEEF, 32'h0, 4'b1000, "wr5");
    step(1'b0, 0, 0, 0, 1, 9'h0, 9'h0, 9'h0, 9'h005, 32'h0, 32'h0, 4'b0001, "rd5");
    check("rd5_value", rd_data_1, 32'hDEADBEEF);

    step(1'b0, 1, 0, 0, 1, 9'h1FF, 9'h0, 9'h0, 9'h1FF, 32'h12345678, 32'h0, 4'b1001, "collide");
    check("collide_value", rd_data_1, 32'h12345678);

    random_run(300);

    // clear in RUN with a read in flight, then a full zero sweep.
    step(1'b0, 1, 0, 0, 0, 9'h005, 9'h0, 9'h0, 9'h0, 32'hDEADBEEF, 32'h0, 4'b1000, "wr5b");
    step(1'b1, 0, 0, 1, 0, 9'h0, 9'h0, 9'h005, 9'h0, 32'h0, 32'h0, 4'b0010, "clr");
    check("clr_read_value", rd_data_0, 32'hDEADBEEF);
    sweep(DEPTH);
    step(1'b0, 0, 0, 1, 0, 9'h0, 9'h0, 9'h005, 9'h0, 32'h0, 32'h0, 4'b0010, "rd5_zero");
    check("rd5_zero_value", rd_data_0, 32'h0);

    // Reset asserted partway through a sweep.
    step(1'b1, 0, 0, 0, 0, 9'h0, 9'h0, 9'h0, 9'h0, 32'h0, 32'h0, 4'b0000, "clr2");
    sweep(200);
    reset = 1'b0;
    #1;
    check("midreset_state", {init_done, ram_we, ram_re, wr_gnt_0, wr_gnt_1, rd_gnt_0, rd_gnt_1,
                             rd_valid_0, rd_valid_1}, 9'h0);
    check("midreset_rdata", {rd_data_0, rd_data_1}, 64'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    reset_model();
    sweep(DEPTH);

    // After reset the tie-break starts from requester 0 again.
    step(1'b0, 1, 1, 1, 1, 9'h010, 9'h011, 9'h010, 9'h011, $urandom, $urandom, 4'b1010, "post_reset_tie");
    random_run(150);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
